riscv_inst_enc_loader: RTL and testbench



---
 rtl/riscv_inst_enc_loader_if.sv | 19 +
 rtl/riscv_inst_enc_loader.sv | 76 +++++++
 tb/tb_riscv_inst_enc_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_inst_enc_loader_if.sv
// riscv_inst_enc_loader_if: field-bundle handshake and IMEM write port of the instruction encoder/loader
interface riscv_inst_enc_loader_if #(parameter int XLEN = 32, parameter int DEPTH = 256);
  localparam int AW = $clog2(DEPTH);
  logic start, finish, valid, ready;
  logic [2:0] fmt;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [XLEN-1:0] imm;
  logic imem_we;
  logic [AW-1:0] imem_addr;
  logic [XLEN-1:0] imem_wdata;
  logic err, done;
  logic [AW:0] count;
  modport master(output start, finish, valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
                 input ready, imem_we, imem_addr, imem_wdata, err, count, done);
  modport slave(input start, finish, valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
                output ready, imem_we, imem_addr, imem_wdata, err, count, done);
endinterface

// File: rtl/riscv_inst_enc_loader.sv
// riscv_inst_enc_loader: packs RV32I fields into words and streams them into IMEM; INST_ENC_RANGE_CHK_EN adds immediate range checks
module riscv_inst_enc_loader #(
  parameter int XLEN = 32,
  parameter int DEPTH = 256,
  parameter int BASE_ADDR = 0
) (
  input logic clk,
  input logic rst,
  riscv_inst_enc_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;
  state_t state, state_nxt;
  logic [AW:0] ptr;
  logic [XLEN-1:0] enc;
  logic rng_ok, ok, xfer;
  assign bus.ready = (state == LOAD) && (ptr < (AW+1)'(DEPTH));
  // a rewind in the same cycle wins over any offered bundle
  assign xfer = bus.valid && bus.ready && !bus.start;
  assign ok = (bus.fmt < 3'd6) && (bus.opcode[1:0] == 2'b11) && rng_ok;
  assign bus.count = ptr - (AW+1)'(BASE_ADDR);
  assign bus.done = (state == DONE);
  always_comb begin
    enc = '0;
    case (bus.fmt)
      3'd0: enc = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd2: enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      3'd3: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:1], bus.imm[11], bus.opcode};
      3'd4: enc = {bus.imm[31:12], bus.rd, bus.opcode};
      3'd5: enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
      default: enc = '0;
    endcase
  end
`ifdef INST_ENC_RANGE_CHK_EN
  function automatic logic fits(input logic [XLEN-1:0] v, input int n);
    logic [XLEN-1:0] s;
    s = $signed(v) >>> (n - 1);
    return (s == '0) || (s == '1);
  endfunction
  always_comb begin
    rng_ok = (bus.fmt == 3'd1 || bus.fmt == 3'd2) ? fits(bus.imm, 12) :
             (bus.fmt == 3'd3) ? fits(bus.imm, 13) && !bus.imm[0] :
             (bus.fmt == 3'd5) ? fits(bus.imm, 21) && !bus.imm[0] :
             (bus.fmt == 3'd4) ? (bus.imm[11:0] == 12'd0) : 1'b1;
  end
`else
  assign rng_ok = 1'b1;
`endif
  always_comb begin
    state_nxt = state;
    if (bus.start) state_nxt = LOAD;
    else if (bus.finish && (state == LOAD || state == FULL)) state_nxt = DONE;
    else if (xfer && ok && ptr == (AW+1)'(DEPTH - 1)) state_nxt = FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= (AW+1)'(BASE_ADDR);
      bus.imem_we <= 1'b0;
      bus.err <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
    end else begin
      state <= state_nxt;
      bus.imem_we <= xfer && ok;
      bus.err <= xfer && !ok;
      if (bus.start) ptr <= (AW+1)'(BASE_ADDR);
      else if (xfer && ok) begin
        ptr <= ptr + 1'b1;
        bus.imem_addr <= ptr[AW-1:0];
        bus.imem_wdata <= enc;
      end
    end
  end
endmodule

// File: tb/tb_riscv_inst_enc_loader.sv
// tb_riscv_inst_enc_loader: directed vectors against hand-encoded RV32I words, DEPTH=4 to reach FULL
module tb_riscv_inst_enc_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int writes;
  riscv_inst_enc_loader_if #(.XLEN(32), .DEPTH(4)) bus();
  riscv_inst_enc_loader #(.XLEN(32), .DEPTH(4), .BASE_ADDR(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.start = 0; bus.finish = 0; bus.valid = 0; bus.fmt = 0; bus.opcode = 0;
    bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.funct3 = 0; bus.funct7 = 0; bus.imm = 0;
  endtask
  task automatic put(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] imm);
    bus.valid = 1; bus.fmt = fmt; bus.opcode = opc; bus.rd = rd; bus.rs1 = rs1;
    bus.rs2 = rs2; bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
    @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.valid = 0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  initial begin
    idle();
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_we", 32'(bus.imem_we), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("idle_no_write", 32'(bus.imem_we), 0);
    pulse_start();
    chk("load_ready", 32'(bus.ready), 1);
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("i_we", 32'(bus.imem_we), 1);
    chk("i_addr", 32'(bus.imem_addr), 0);
    chk("i_wdata", bus.imem_wdata, 32'h00500093);
    chk("i_count", 32'(bus.count), 1);
    pulse_start();
    chk("restart_count", 32'(bus.count), 0);
    put(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("r_wdata", bus.imem_wdata, 32'h002081B3);
    chk("r_addr", 32'(bus.imem_addr), 0);
    put(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    chk("s_we", 32'(bus.imem_we), 1);
    chk("s_wdata", bus.imem_wdata, 32'h0020A223);
    chk("s_addr", 32'(bus.imem_addr), 1);
    chk("s_count", 32'(bus.count), 2);
    pulse_start();
    put(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    chk("b_wdata", bus.imem_wdata, 32'h00000463);
    put(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    chk("j_wdata", bus.imem_wdata, 32'h010000EF);
    put(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    chk("u_wdata", bus.imem_wdata, 32'h123452B7);
    chk("u_addr", 32'(bus.imem_addr), 2);
    put(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("fmt7_err", 32'(bus.err), 1);
    chk("fmt7_we", 32'(bus.imem_we), 0);
    chk("fmt7_count", 32'(bus.count), 3);
    chk("fmt7_addr_hold", 32'(bus.imem_addr), 2);
    put(3'd1, 7'h10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("opc_err", 32'(bus.err), 1);
    chk("opc_we", 32'(bus.imem_we), 0);
    bus.valid = 0;
    @(negedge clk);
    chk("err_pulse_end", 32'(bus.err), 0);
    pulse_start();
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
`ifdef INST_ENC_RANGE_CHK_EN
    chk("i2048_err", 32'(bus.err), 1);
    chk("i2048_count", 32'(bus.count), 0);
`else
    chk("i2048_wdata", bus.imem_wdata, 32'h80000093);
    chk("i2048_count", 32'(bus.count), 1);
`endif
    put(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
`ifdef INST_ENC_RANGE_CHK_EN
    chk("b_odd_err", 32'(bus.err), 1);
`else
    chk("b_odd_wdata", bus.imem_wdata, 32'h00000363);
`endif
    pulse_start();
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      put(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      if (bus.imem_we) writes++;
    end
    bus.valid = 0;
    chk("full_writes", 32'(writes), 4);
    chk("full_ready", 32'(bus.ready), 0);
    chk("full_count", 32'(bus.count), 4);
    chk("full_addr", 32'(bus.imem_addr), 3);
    chk("full_not_done", 32'(bus.done), 0);
    bus.finish = 1;
    @(negedge clk);
    bus.finish = 0;
    chk("finish_done", 32'(bus.done), 1);
    pulse_start();
    chk("rewind_count", 32'(bus.count), 0);
    chk("rewind_done", 32'(bus.done), 0);
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("rewind_addr", 32'(bus.imem_addr), 0);
    chk("rewind_we", 32'(bus.imem_we), 1);
    bus.finish = 1;
    put(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    bus.finish = 0;
    bus.valid = 0;
    chk("fin_xfer_we", 32'(bus.imem_we), 1);
    chk("fin_xfer_wdata", bus.imem_wdata, 32'h00100113);
    chk("fin_xfer_done", 32'(bus.done), 1);
    pulse_start();
    rst = 1;
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    rst = 0;
    bus.valid = 0;
    chk("rst_mid_we", 32'(bus.imem_we), 0);
    chk("rst_mid_count", 32'(bus.count), 0);
    chk("rst_mid_ready", 32'(bus.ready), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
